parallel_to_serial: RTL and testbench
=====================================

# parallel_to_serial

Splits one wide word (RATIO × DATA_W bits) into RATIO narrow words emitted back-to-back, most-significant slice first. It is the inverse of the serial-to-parallel packer: a word packed as {first, second} is unpacked here as first, then second. It sits on the HOG/SVM datapath wherever a double-width stream must re-enter a single-width interface, for example feature-buffer readout or SRAM write-back. Ready/valid handshakes on both sides allow full throughput under back-pressure.

## Interface
- DATA_W, 32, width of one output slice
- RATIO, 2, slices per input word; must be ≥ 2
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- clear  in  1  synchronous flush; drops the held word and returns to IDLE
- i_data  in  DATA_W*RATIO  wide input word
- i_valid  in  1  i_data is valid
- i_ready  out  1  block can accept i_data this cycle
- o_data  out  DATA_W  current output slice
- o_valid  out  1  o_data is valid
- o_last  out  1  o_data is the final slice of the current word
- o_ready  in  1  downstream accepts o_data this cycle

## Operation
- State machine, 2 states:
  - IDLE: nothing held.
  - SHIFT: a word is held in shift register `sreg`; down-counter `cnt` holds the number of slices remaining.
- Input accept: `acc = i_valid & i_ready`.
- Output accept: `emit = o_valid & o_ready`.
- i_ready = (state == IDLE) | (o_last & o_ready). Combinational, so the block can reload on the same cycle the last slice leaves. i_ready is forced to 0 while rst or clear is high.
- IDLE, on acc:
  - sreg ← i_data
  - cnt ← RATIO
  - go to SHIFT
- SHIFT, on emit without o_last:
  - sreg ← sreg << DATA_W (zero-fill)
  - cnt ← cnt − 1
- SHIFT, on emit with o_last:
  - if acc: reload (sreg ← i_data, cnt ← RATIO) and stay in SHIFT
  - else: go to IDLE
- o_data = sreg[DATA_W*RATIO−1 -: DATA_W], so the MSB slice goes out first.
- o_valid = (state == SHIFT).
- o_last = (state == SHIFT) & (cnt == 1).
- While o_valid is high and o_ready is low, o_data, o_valid and o_last hold stable. Valid is never withdrawn.
- clear (takes priority over everything except rst): state ← IDLE, cnt ← 0, sreg ← 0. An in-flight word is discarded without producing o_last.
- rst asserted mid-word behaves like clear, and also applies reset values.
- Reset values: state IDLE, sreg 0, cnt 0. Outputs: o_valid 0, o_last 0, o_data 0, i_ready 0 while rst is high and 1 on the first cycle after rst falls.
- cnt width CNT_W = $clog2(RATIO+1). Counting never wraps: cnt only decrements in SHIFT, where cnt ≥ 1.

## Timing
- Latency: a word accepted on cycle N presents its first slice (o_valid = 1) on cycle N+1.
- Throughput with o_ready held at 1: exactly one slice per cycle and no bubbles between words. i_ready pulses high on every RATIO-th cycle, coincident with o_last.
- Back-pressure: i_ready rises only in the cycle where o_last & o_ready, or in IDLE. Input is never accepted while non-final slices remain.
- Combinational paths: o_ready → i_ready only. There is no path from i_valid to any output.
- acc, emit and clear in the same cycle: clear wins and the input word is not captured, because i_ready is 0.

## Structure
- Shared package `hog_pkg`:
  - CNT_W helper function (clog2)
  - state encoding localparams ST_IDLE = 1'b0, ST_SHIFT = 1'b1
- One natural sub-module, `slice_counter`:
  - loadable down-counter with load, dec and clear inputs
  - outputs cnt and is_one
  - mirrors the buffer_ctr role on the packer side
- Top level holds the FSM, sreg and handshake logic. Target is about 150–250 lines total.

## Test plan
- Reset: hold rst 3 cycles with i_valid = 1 → o_valid = 0, o_data = 0, i_ready = 0 during reset; i_ready = 1 on the first cycle after release.
- Basic split (DATA_W = 32, RATIO = 2): i_data = 0xAAAA0001_BBBB0002, o_ready = 1 → cycle N+1 o_data = 0xAAAA0001 with o_last = 0; cycle N+2 o_data = 0xBBBB0002 with o_last = 1; then o_valid = 0.
- Streaming: 4 words back-to-back with i_valid and o_ready held at 1 → 8 consecutive slices with no gaps, MSB-first order, o_last on every 2nd slice, i_ready = 1 exactly on those o_last cycles.
- Back-pressure: drop o_ready for 5 cycles mid-word → o_data/o_valid/o_last stable throughout, i_ready = 0, no slice lost or duplicated after o_ready returns.
- Clear mid-word: assert clear after the first slice → the next cycle has o_valid = 0 and i_ready = 1; the next accepted word 0x11111111_22222222 is emitted intact starting with 0x11111111.
- Scoreboard with RATIO = 4 and random i_valid/o_ready → the concatenation of output slices equals the input words MSB-first, and o_last count equals the number of accepted words.

Source files
------------

// File: rtl/hog_pkg.sv
// Shared definitions for the HOG/SVM datapath width-conversion blocks.
package hog_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter must hold RATIO itself, not just RATIO-1.
  function automatic int unsigned cnt_w(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/parallel_to_serial_slice_counter.sv
// Loadable down-counter tracking how many slices of the held word remain.
module slice_counter
  import hog_pkg::*;
#(
  parameter int unsigned RATIO = 2,
  parameter int unsigned CNT_W = cnt_w(RATIO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(RATIO);
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/parallel_to_serial.sv
// Splits a RATIO*DATA_W word into RATIO slices, MSB slice first, with
// ready/valid on both sides and same-cycle reload after the last slice.
module parallel_to_serial
  import hog_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RATIO  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [DATA_W*RATIO-1:0] i_data,
  input  logic                    i_valid,
  output logic                    i_ready,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_valid,
  output logic                    o_last,
  input  logic                    o_ready
);

  localparam int unsigned CNT_W  = cnt_w(RATIO);
  localparam int unsigned WIDE_W = DATA_W * RATIO;

  state_t             state;
  state_t             state_n;
  logic [WIDE_W-1:0]  sreg;
  logic [CNT_W-1:0]   cnt;
  logic               is_one;
  logic               load;
  logic               dec;
  logic               acc;
  logic               emit;

  assign o_valid = (state == ST_SHIFT);
  assign o_last  = o_valid & is_one;
  assign o_data  = sreg[WIDE_W-1 -: DATA_W];
  assign i_ready = ~rst & ~clear & (~o_valid | (o_last & o_ready));
  assign acc     = i_valid & i_ready;
  assign emit    = o_valid & o_ready;

  always_comb begin
    state_n = state;
    load    = 1'b0;
    dec     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (acc) begin
          load    = 1'b1;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (emit) begin
          if (!is_one) begin
            // Zero check keeps the counter from ever wrapping.
            dec = (cnt != '0);
          end else if (acc) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= i_data;
    end else if (dec) begin
      sreg <= sreg << DATA_W;
    end
  end

  slice_counter #(
    .RATIO (RATIO),
    .CNT_W (CNT_W)
  ) u_slice_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .load   (load),
    .dec    (dec),
    .cnt    (cnt),
    .is_one (is_one)
  );

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed checks on a 32x2 instance plus a randomized scoreboard on 8x4.
module tb_parallel_to_serial;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_clear;
  logic [63:0] a_i_data;
  logic        a_i_valid;
  logic        a_i_ready;
  logic [31:0] a_o_data;
  logic        a_o_valid;
  logic        a_o_last;
  logic        a_o_ready;

  logic        b_clear;
  logic [31:0] b_i_data;
  logic        b_i_valid;
  logic        b_i_ready;
  logic [7:0]  b_o_data;
  logic        b_o_valid;
  logic        b_o_last;
  logic        b_o_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  parallel_to_serial #(
    .DATA_W (32),
    .RATIO  (2)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .clear   (a_clear),
    .i_data  (a_i_data),
    .i_valid (a_i_valid),
    .i_ready (a_i_ready),
    .o_data  (a_o_data),
    .o_valid (a_o_valid),
    .o_last  (a_o_last),
    .o_ready (a_o_ready)
  );

  parallel_to_serial #(
    .DATA_W (8),
    .RATIO  (4)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .clear   (b_clear),
    .i_data  (b_i_data),
    .i_valid (b_i_valid),
    .i_ready (b_i_ready),
    .o_data  (b_o_data),
    .o_valid (b_o_valid),
    .o_last  (b_o_last),
    .o_ready (b_o_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic v, input logic [31:0] d,
                         input logic l, input logic r);
    check({tag, "_valid"}, a_o_valid, v);
    if (v) begin
      check({tag, "_data"}, a_o_data, d);
      check({tag, "_last"}, a_o_last, l);
    end
    check({tag, "_iready"}, a_i_ready, r);
  endtask

  logic [63:0] words [4];
  logic [7:0]  exp_q [$];
  logic        last_q [$];

  initial begin
    words[0] = 64'h0000_00A1_0000_00A2;
    words[1] = 64'h0000_00B1_0000_00B2;
    words[2] = 64'h0000_00C1_0000_00C2;
    words[3] = 64'h0000_00D1_0000_00D2;

    rst       = 1'b1;
    a_clear   = 1'b0;
    a_i_valid = 1'b1;
    a_i_data  = 64'h1234_5678_9ABC_DEF0;
    a_o_ready = 1'b1;
    b_clear   = 1'b0;
    b_i_valid = 1'b0;
    b_i_data  = '0;
    b_o_ready = 1'b0;

    // Reset held 3 cycles with a valid input offered
    repeat (3) begin
      tick();
      check("rst_ovalid", a_o_valid, 1'b0);
      check("rst_odata", a_o_data, 32'h0);
      check("rst_iready", a_i_ready, 1'b0);
      check("rst_b_ovalid", b_o_valid, 1'b0);
    end
    rst       = 1'b0;
    a_i_valid = 1'b0;
    #1;
    check("rst_release_iready", a_i_ready, 1'b1);
    tick();

    // Basic split
    a_i_valid = 1'b1;
    a_i_data  = 64'hAAAA0001_BBBB0002;
    #1;
    check("basic_accept_iready", a_i_ready, 1'b1);
    tick();
    a_i_valid = 1'b0;
    #1;
    check_a("basic_s0", 1'b1, 32'hAAAA0001, 1'b0, 1'b0);
    tick();
    check_a("basic_s1", 1'b1, 32'hBBBB0002, 1'b1, 1'b1);
    tick();
    check("basic_done_valid", a_o_valid, 1'b0);

    // Streaming 4 words back-to-back
    a_i_valid = 1'b1;
    a_i_data  = words[0];
    tick();
    for (int s = 0; s < 8; s++) begin
      if (s % 2 == 1) begin
        if (s / 2 < 3) a_i_data = words[s / 2 + 1];
        else           a_i_valid = 1'b0;
      end
      #1;
      check_a("stream", 1'b1,
              (s % 2 == 0) ? words[s / 2][63:32] : words[s / 2][31:0],
              (s % 2 == 1), (s % 2 == 1));
      tick();
    end
    check("stream_done_valid", a_o_valid, 1'b0);

    // Back-pressure on the final slice
    a_i_valid = 1'b1;
    a_i_data  = 64'hCAFE0001_DEAD0002;
    tick();
    a_i_data = 64'h5555_5555_6666_6666;
    #1;
    check_a("bp_s0", 1'b1, 32'hCAFE0001, 1'b0, 1'b0);
    tick();
    a_o_ready = 1'b0;
    repeat (5) begin
      #1;
      check_a("bp_stall", 1'b1, 32'hDEAD0002, 1'b1, 1'b0);
      tick();
    end
    a_o_ready = 1'b1;
    a_i_valid = 1'b0;
    #1;
    check_a("bp_release", 1'b1, 32'hDEAD0002, 1'b1, 1'b1);
    tick();
    check("bp_done_valid", a_o_valid, 1'b0);

    // Clear mid-word, with a competing input offered during clear
    a_i_valid = 1'b1;
    a_i_data  = 64'h33333333_44444444;
    tick();
    a_i_valid = 1'b0;
    #1;
    check_a("clr_s0", 1'b1, 32'h33333333, 1'b0, 1'b0);
    tick();
    a_clear   = 1'b1;
    a_i_valid = 1'b1;
    a_i_data  = 64'h99999999_88888888;
    #1;
    check("clr_iready_low", a_i_ready, 1'b0);
    tick();
    a_clear   = 1'b0;
    a_i_data  = 64'h11111111_22222222;
    #1;
    check("clr_after_valid", a_o_valid, 1'b0);
    check("clr_after_iready", a_i_ready, 1'b1);
    tick();
    a_i_valid = 1'b0;
    #1;
    check_a("clr_n0", 1'b1, 32'h11111111, 1'b0, 1'b0);
    tick();
    check_a("clr_n1", 1'b1, 32'h22222222, 1'b1, 1'b1);
    tick();
    check("clr_done_valid", a_o_valid, 1'b0);

    // Randomized scoreboard, RATIO = 4
    begin
      int          sent     = 0;
      int          last_cnt = 0;
      logic [31:0] next_word;
      next_word = $urandom;
      for (int cyc = 0; cyc < 800 && !(sent == 24 && exp_q.size() == 0); cyc++) begin
        b_i_valid = (sent < 24) && ($urandom_range(0, 3) != 0);
        b_i_data  = next_word;
        b_o_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (b_o_valid && b_o_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_slice", 1'b1, 1'b0);
          end else begin
            check("sb_data", b_o_data, exp_q.pop_front());
            check("sb_last", b_o_last, last_q.pop_front());
          end
          if (b_o_last) last_cnt++;
        end
        if (b_i_valid && b_i_ready) begin
          for (int k = 0; k < 4; k++) begin
            exp_q.push_back(next_word[31 - 8 * k -: 8]);
            last_q.push_back(k == 3);
          end
          sent++;
          next_word = $urandom;
        end
        tick();
      end
      check("sb_words_sent", sent, 24);
      check("sb_last_count", last_cnt, sent);
      check("sb_drained", exp_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
